div_ctl: RTL and testbench
==========================

# div_ctl

Multi-requester sequencer for the shared 33-cycle iterative divider (`divide`) in the out-of-order core's execute stage.
- Accepts divide requests from NUM_REQ issue ports and grants them round-robin, one operation at a time.
- Registers and holds the operands, pulses the divider start, waits for its ready, then returns a tagged result with a valid/ready handshake.
- Divide-by-zero may be short-circuited without occupying the divider.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (≥1)
- TAG_W, 4, width of the reorder/RS tag carried through
- ID_W, 1, requester-index width, ≥ max(1, clog2(NUM_REQ))

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request pending, per requester
- req_ready  out  NUM_REQ  one-hot accept strobe, high for one cycle
- req_dividend  in  NUM_REQ*32  packed, requester i at [32i+31:32i]
- req_divisor  in  NUM_REQ*32  packed as above
- req_tag  in  NUM_REQ*TAG_W  packed
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  ID_W  index of the granted requester
- resp_tag  out  TAG_W  tag of the granted request
- resp_result  out  32  quotient
- resp_exception  out  1  divide by zero
- busy  out  1  high in any state other than IDLE
- div_start  out  1  to divider ctrl_div; one-cycle pulse
- div_dividend  out  32  registered operand to divider
- div_divisor  out  32  registered operand to divider
- div_result  in  32  divider quotient
- div_ready  in  1  divider done
- div_exception  in  1  divider zero-divisor flag

## Operation
FSM states: IDLE, START, WAIT, RESP.
- IDLE
  - If any req_valid is high, the arbiter picks the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - Same cycle: assert req_ready[g] and capture the operands, tag and g.
  - Next state: START, or RESP under zero bypass (see Configuration).
  - With no req_valid, stay in IDLE.
- START
  - div_start=1 for exactly this one cycle.
  - Next state: WAIT.
- WAIT
  - div_start=0.
  - On div_ready=1: capture div_result and div_exception, then go to RESP.
  - Otherwise stay in WAIT.
- RESP
  - resp_valid=1, and all resp_* outputs are held stable.
  - On resp_ready=1: go to IDLE and set rr_ptr=(g+1) mod NUM_REQ.
- div_dividend and div_divisor are held constant from START until the next IDLE accept. The divider samples its operands every cycle, so they must not change during an operation.
- req_ready is never asserted outside IDLE; at most one bit is high in any cycle.
- A requester that drops req_valid before being granted is not served. No request is buffered.
- NUM_REQ=1: the arbiter degenerates to a direct grant, and rr_ptr stays 0.

## Timing
- Reset (asynchronous assert) forces:
  - state=IDLE, rr_ptr=0
  - req_ready=0, resp_valid=0, resp_id=0, resp_tag=0, resp_result=0, resp_exception=0
  - busy=0, div_start=0, div_dividend=0, div_divisor=0
- Reset asserted mid-operation abandons the operation and produces no response. The divider itself has no reset; the next div_start restarts its counter.
- div_ready is ignored in IDLE, START and RESP. This hides the stale ready left over from the previous operation.
- Latency, accept cycle = 0:
  - div_start at cycle 1.
  - resp_valid at cycle 2+D, where D is the number of cycles after div_start until div_ready is first high in WAIT. D=33 for the current divider, giving resp_valid at cycle 35.
- Zero-bypass latency: resp_valid at cycle 1.
- Back-to-back throughput: next accept in the cycle after the resp_ready handshake.
- resp_ready held high while in RESP: RESP lasts one cycle.

## Configuration
- DIV_CTL_ZERO_BYPASS_EN defined:
  - In IDLE, if the granted divisor is 32'h0, skip START and WAIT and go straight to RESP.
  - Response: resp_result=32'h0, resp_exception=1.
  - div_start is not pulsed, and the div_* operands are not updated.
- Not defined:
  - Every request goes through the divider.
  - resp_exception=div_exception and resp_result=div_result, both captured in WAIT.

## Structure
- Package div_ctl_pkg holds:
  - the state enum (IDLE, START, WAIT, RESP)
  - DIV_W=32
  - the divider latency constant DIV_LAT=33, used by benches only
- Sub-module rr_arbiter(NUM_REQ):
  - inputs: request vector and rr_ptr
  - outputs: one-hot grant and grant index
  - purely combinational

## Test plan
- Single request (requester 0, 100/7, tag 3) -> req_ready[0] at cycle 0, div_start at cycle 1, resp_valid at cycle 35 with resp_result=14, resp_tag=3, resp_id=0, resp_exception=0.
- Both requesters valid continuously, with rr_ptr=0 after reset -> grants alternate 0,1,0,1. Negative operands (-100/7) give resp_result=-14 (32'hFFFFFFF2).
- Divisor=0 with DIV_CTL_ZERO_BYPASS_EN -> resp_valid at cycle 1, resp_result=0, resp_exception=1, no div_start. Without the macro -> div_start pulses and resp_exception=1 after D cycles.
- Hold resp_ready=0 for 10 cycles in RESP -> resp_* stable, no req_ready, busy=1. Releasing resp_ready -> IDLE the next cycle.
- Assert reset_n=0 in WAIT -> all outputs take their reset values asynchronously. After release, a new request completes correctly, with stale div_ready ignored in START.

Source files
------------

// File: rtl/div_ctl_pkg.sv
// Shared types and constants for the divider sequencer (div_ctl).
// Optional build macro: DIV_CTL_ZERO_BYPASS_EN (answer divide-by-zero without the divider).
package div_ctl_pkg;

  localparam int unsigned DIV_W   = 32;
  localparam int unsigned DIV_LAT = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
  } div_ops_t;

endpackage

// File: rtl/div_ctl_if.sv
// Request, response and divider-side signals of div_ctl.
// The sequencer uses the slave modport; the issue ports, consumer and divider see the master modport.
interface div_ctl_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned ID_W    = 1
);
  import div_ctl_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*DIV_W-1:0] req_dividend;
  logic [NUM_REQ*DIV_W-1:0] req_divisor;
  logic [NUM_REQ*TAG_W-1:0] req_tag;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [TAG_W-1:0]         resp_tag;
  logic [DIV_W-1:0]         resp_result;
  logic                     resp_exception;
  logic                     busy;

  logic                     div_start;
  logic [DIV_W-1:0]         div_dividend;
  logic [DIV_W-1:0]         div_divisor;
  logic [DIV_W-1:0]         div_result;
  logic                     div_ready;
  logic                     div_exception;

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_tag,
    output req_ready,
    output resp_valid, resp_id, resp_tag, resp_result, resp_exception, busy,
    input  resp_ready,
    output div_start, div_dividend, div_divisor,
    input  div_result, div_ready, div_exception
  );

  modport master (
    output req_valid, req_dividend, req_divisor, req_tag,
    input  req_ready,
    input  resp_valid, resp_id, resp_tag, resp_result, resp_exception, busy,
    output resp_ready,
    input  div_start, div_dividend, div_divisor,
    output div_result, div_ready, div_exception
  );

endinterface

// File: rtl/div_ctl_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_vld_o
);

  // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!gnt_vld_o && req_i[j] && (j >= 32'(ptr_i))) begin
        gnt_vld_o = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!gnt_vld_o && req_i[j]) begin
        gnt_vld_o = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/div_ctl.sv
// Round-robin sequencer sharing one iterative divider among NUM_REQ issue ports.
// Optional build macro: DIV_CTL_ZERO_BYPASS_EN (zero divisor answered directly, divider untouched).
module div_ctl
  import div_ctl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned ID_W    = 1
) (
  input logic       clk,
  input logic       reset_n,
  div_ctl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [DIV_W-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  div_ops_t         ops_q, ops_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic             div_start_q, div_start_d;

  logic [NUM_REQ-1:0] gnt_c;
  logic [ID_W-1:0]    gnt_idx_c;
  logic               gnt_vld_c;
  div_ops_t           sel_ops_c;
  logic [TAG_W-1:0]   sel_tag_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_c),
    .gnt_idx_o (gnt_idx_c),
    .gnt_vld_o (gnt_vld_c)
  );

  // One-hot mux of the granted requester's payload.
  always_comb begin
    sel_ops_c = '0;
    sel_tag_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        sel_ops_c.dividend = bus.req_dividend[i*DIV_W +: DIV_W];
        sel_ops_c.divisor  = bus.req_divisor[i*DIV_W +: DIV_W];
        sel_tag_c          = bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    tag_d    = tag_q;
    result_d = result_q;
    exc_d    = exc_q;
    ops_d    = ops_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_vld_c) begin
          id_d  = gnt_idx_c;
          tag_d = sel_tag_c;
`ifdef DIV_CTL_ZERO_BYPASS_EN
          if (sel_ops_c.divisor == '0) begin
            result_d = '0;
            exc_d    = 1'b1;
            state_d  = RESP;
          end else begin
            ops_d   = sel_ops_c;
            state_d = START;
          end
`else
          ops_d   = sel_ops_c;
          state_d = START;
`endif
        end
      end
      START: state_d = WAIT;
      // div_ready is only honoured here; elsewhere it may be stale.
      WAIT: begin
        if (bus.div_ready) begin
          result_d = bus.div_result;
          exc_d    = bus.div_exception;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (32'(id_q) == NUM_REQ - 1) ? '0 : id_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    resp_valid_d = (state_d == RESP);
    busy_d       = (state_d != IDLE);
    div_start_d  = (state_d == START);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      tag_q        <= '0;
      result_q     <= '0;
      exc_q        <= 1'b0;
      ops_q        <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      div_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      tag_q        <= tag_d;
      result_q     <= result_d;
      exc_q        <= exc_d;
      ops_q        <= ops_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      div_start_q  <= div_start_d;
    end
  end

  // Accept strobe is same-cycle with the request, so it is gated by reset directly.
  assign bus.req_ready      = (state_q == IDLE && reset_n) ? gnt_c : '0;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_id        = id_q;
  assign bus.resp_tag       = tag_q;
  assign bus.resp_result    = result_q;
  assign bus.resp_exception = exc_q;
  assign bus.busy           = busy_q;
  assign bus.div_start      = div_start_q;
  assign bus.div_dividend   = ops_q.dividend;
  assign bus.div_divisor    = ops_q.divisor;

endmodule

// File: tb/tb_div_ctl.sv
// Self-checking bench for div_ctl with a behavioural 33-cycle divider and a response scoreboard.
module tb_div_ctl;
  import div_ctl_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned TW = 4;
`ifdef DIV_CTL_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [0:0]  id;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  int   rr_m = 0;

  div_ctl_if #(.NUM_REQ(NR), .TAG_W(TW), .ID_W(1)) bus ();

  div_ctl #(.NUM_REQ(NR), .TAG_W(TW), .ID_W(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Divider model: operands latched on div_start, ready DIV_LAT cycles later, no reset.
  logic [5:0]  dm_cnt = '0;
  logic        dm_rdy = 1'b0;
  logic [31:0] dm_res = '0;
  logic        dm_exc = 1'b0;
  always @(posedge clk) begin
    if (bus.div_start) begin
      dm_cnt <= 6'(DIV_LAT - 1);
      dm_rdy <= 1'b0;
      if (bus.div_divisor == 32'h0) begin
        dm_res <= 32'hFFFF_FFFF;
        dm_exc <= 1'b1;
      end else begin
        dm_res <= 32'($signed(bus.div_dividend) / $signed(bus.div_divisor));
        dm_exc <= 1'b0;
      end
    end else if (dm_cnt > 6'd1) begin
      dm_cnt <= dm_cnt - 6'd1;
    end else if (dm_cnt == 6'd1) begin
      dm_cnt <= '0;
      dm_rdy <= 1'b1;
    end
  end
  assign bus.div_ready     = dm_rdy;
  assign bus.div_result    = dm_res;
  assign bus.div_exception = dm_exc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return BYP ? {1'b1, 32'h0} : {1'b1, 32'hFFFF_FFFF};
    return {1'b0, 32'($signed(a) / $signed(b))};
  endfunction

  function automatic int exp_grant(input logic [NR-1:0] v, input int ptr);
    for (int i = 0; i < int'(NR); i++) begin
      if (v[(ptr + i) % int'(NR)]) return (ptr + i) % int'(NR);
    end
    return -1;
  endfunction

  // Scoreboard: push at accept, pop at response handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.req_ready != '0) begin
        int   g;
        exp_t e;
        g = bus.req_ready[1] ? 1 : 0;
        check_eq("grant_onehot", 64'($countones(bus.req_ready)), 64'(1));
        check_eq("grant_rr", 64'(g), 64'(exp_grant(bus.req_valid, rr_m)));
        e.id  = 1'(g);
        e.tag = bus.req_tag[g*TW +: TW];
        {e.exc, e.res} = ref_div(bus.req_dividend[g*32 +: 32], bus.req_divisor[g*32 +: 32]);
        sb_q.push_back(e);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("resp_id", 64'(bus.resp_id), 64'(e.id));
          check_eq("resp_tag", 64'(bus.resp_tag), 64'(e.tag));
          check_eq("resp_result", 64'(bus.resp_result), 64'(e.res));
          check_eq("resp_exc", 64'(bus.resp_exception), 64'(e.exc));
          rr_m = (int'(e.id) + 1) % int'(NR);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    bus.req_dividend[i*32 +: 32] = a;
    bus.req_divisor[i*32 +: 32]  = b;
    bus.req_tag[i*TW +: TW]      = t;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctl"}, 64'({bus.req_ready, bus.resp_valid, bus.busy, bus.div_start,
                                 bus.resp_id, bus.resp_tag, bus.resp_exception}), 64'(0));
    check_eq({tag, "_result"}, 64'(bus.resp_result), 64'(0));
    check_eq({tag, "_ops"}, {bus.div_dividend, bus.div_divisor}, 64'(0));
  endtask

  // Call right after driving a request at posedge+1; times from the accept cycle.
  task automatic run_op(input bit drop, output int lat, output int st_cyc);
    int cyc;
    lat = -1; st_cyc = -1; cyc = 0;
    @(negedge clk);
    check_eq("accept", 64'(bus.req_ready != '0), 64'(1));
    if (drop) begin @(posedge clk); #1; bus.req_valid = '0; end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.div_start && st_cyc < 0) st_cyc = cyc;
      if (bus.resp_valid) begin lat = cyc; break; end
    end
    if (lat < 0) check_eq("resp_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!bus.busy && !bus.resp_valid) done = 1'b1;
    end
    check_eq("idle_timeout", 64'(done), 64'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    sb_q.delete();
    rr_m = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int lat, st;
    bit found;
    bus.req_valid = '1;
    bus.req_dividend = '0; bus.req_divisor = '0; bus.req_tag = '0;
    bus.resp_ready = 1'b1;

    // Reset state, with requests pending so req_ready gating is exercised.
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk); #1;
    bus.req_valid = '0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single request 100/7 tag 3 from requester 0.
    #1;
    set_req(0, 32'd100, 32'd7, 4'd3);
    bus.req_valid = 2'b01;
    run_op(1'b1, lat, st);
    check_eq("single_start_cyc", 64'(st), 64'(1));
    check_eq("single_lat", 64'(lat), 64'(2 + DIV_LAT));
    check_eq("single_result", 64'(bus.resp_result), 64'(14));
    check_eq("single_tag_id", 64'({bus.resp_tag, bus.resp_id, bus.resp_exception}), 64'({4'd3, 1'b0, 1'b0}));
    wait_idle();

    // Both requesters continuously valid: grants alternate from 0.
    do_reset();
    set_req(0, 32'd100, 32'd7, 4'd1);
    set_req(1, -32'sd100, 32'd7, 4'd2);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
        @(negedge clk);
        if (bus.resp_valid) found = 1'b1;
      end
      check_eq("rr_found", 64'(found), 64'(1));
      check_eq("rr_id", 64'(bus.resp_id), 64'(i % 2));
      check_eq("rr_result", 64'(bus.resp_result), (i % 2) ? 64'(32'hFFFF_FFF2) : 64'(14));
      @(negedge clk);
      check_eq("b2b_accept", 64'(bus.req_ready != '0), 64'(1));
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();

    // Divide by zero; last divider operands were 100/7 from requester 0.
    @(posedge clk); #1;
    set_req(0, 32'd55, 32'd0, 4'd5);
    bus.req_valid = 2'b01;
    run_op(1'b1, lat, st);
    check_eq("zero_lat", 64'(lat), BYP ? 64'(1) : 64'(2 + DIV_LAT));
    check_eq("zero_start_cyc", 64'(st), BYP ? 64'(-1) : 64'(1));
    check_eq("zero_exc", 64'(bus.resp_exception), 64'(1));
    check_eq("zero_divisor_out", 64'(bus.div_divisor), BYP ? 64'(7) : 64'(0));
    wait_idle();

    // Consumer stalls for 10 cycles in RESP while another request waits.
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    set_req(1, 32'd20, 32'd3, 4'd9);
    bus.req_valid = 2'b10;
    run_op(1'b1, lat, st);
    @(posedge clk); #1;
    set_req(0, 32'd9, 32'd3, 4'd2);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("hold_stable", 64'({bus.resp_valid, bus.busy, bus.req_ready, bus.resp_result, bus.resp_tag, bus.resp_id}),
               64'({1'b1, 1'b1, 2'b00, 32'd6, 4'd9, 1'b1}));
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check_eq("hold_release_resp", 64'(bus.resp_valid), 64'(1));
    @(negedge clk);
    check_eq("hold_back_idle", 64'({bus.busy, bus.resp_valid}), 64'(0));
    check_eq("hold_next_accept", 64'(bus.req_ready), 64'(2'b01));
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();

    // Reset asserted in WAIT abandons the operation.
    @(posedge clk); #1;
    set_req(0, 32'd1000, 32'd10, 4'd4);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check_eq("rst_accept", 64'(bus.req_ready), 64'(2'b01));
    repeat (5) @(negedge clk);
    check_eq("rst_in_wait", 64'({bus.busy, bus.resp_valid, bus.div_start}), 64'(3'b100));
    #2 reset_n = 1'b0;
    sb_q.delete();
    rr_m = 0;
    #1 check_reset_outs("rst_async");
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("rst_no_resp", 64'({bus.busy, bus.resp_valid}), 64'(0));

    // Fresh request after reset while the divider still shows a stale ready.
    @(posedge clk); #1;
    set_req(1, 32'd42, 32'd6, 4'd7);
    bus.req_valid = 2'b10;
    run_op(1'b1, lat, st);
    check_eq("post_rst_lat", 64'(lat), 64'(2 + DIV_LAT));
    check_eq("post_rst_result", 64'({bus.resp_result, bus.resp_tag, bus.resp_id}), 64'({32'd7, 4'd7, 1'b1}));
    wait_idle();

    check_eq("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
